// File: rtl/nios2_sysid_pkg.sv
// Shared definitions for the system-ID checker.
// Contents:
//  - sysid_chk_state_t   : checker FSM states
//  - SYSID_ADDR_ID/_TS   : Avalon word addresses of the ID and timestamp registers
//  - SYSID_EXPECTED_ID/_TS : default build-time expected values
//  - sysid_word_mismatch : 32-bit compare helper
package nios2_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ID_REQ  = 3'd1,
        ST_RD_ID_WAIT = 3'd2,
        ST_RD_TS_REQ  = 3'd3,
        ST_RD_TS_WAIT = 3'd4,
        ST_FINISH     = 3'd5
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID = 32'd1;
    localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1501838636;

    function automatic logic sysid_word_mismatch(input logic [31:0] observed,
                                                 input logic [31:0] expected);
        return (observed != expected);
    endfunction

endpackage

// File: rtl/nios2_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
// Signals:
//  av_address        word address (0 = ID, 1 = timestamp)
//  av_read           read request
//  av_waitrequest    slave stall, request held while high
//  av_readdata       read data
//  av_readdatavalid  read data qualifier
interface nios2_sysid_checker_if;

    logic        av_address;
    logic        av_read;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;

    modport master (
        output av_address,
        output av_read,
        input  av_waitrequest,
        input  av_readdata,
        input  av_readdatavalid
    );

    modport slave (
        input  av_address,
        input  av_read,
        output av_waitrequest,
        output av_readdata,
        output av_readdatavalid
    );

endinterface

// File: rtl/nios2_sysid_timeout.sv
// Per-transaction timeout counter.
// Ports:
//  clock    in  system clock
//  reset    in  synchronous active-high reset
//  load     in  clear the count (wins over enable)
//  enable   in  count one cycle
//  expired  out count has reached TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1 so it can never wrap back to zero.
module nios2_sysid_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter: clear on load, increment while enabled, hold at the last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_LAST)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_LAST);

endmodule

// File: rtl/nios2_sysid_checker.sv
// System-ID checker: reads the sysid slave's ID word (address 0) and build
// timestamp (address 1) over Avalon-MM, compares both with build-time values
// and reports pass / mismatch / timeout.
// Ports:
//  clock, reset       system clock, synchronous active-high reset
//  start              pulse to begin a check (ignored while busy or finishing)
//  busy               check in progress
//  done               one-cycle pulse when a check completes
//  pass, id_mismatch, ts_mismatch, timeout   sticky result flags of the last check
//  captured_id, captured_ts                   words captured by the last check
//  av                 Avalon-MM master port (nios2_sysid_checker_if.master)
// Build option: SYSID_CHK_AUTOSTART_EN runs one check automatically on the
// first cycle after reset is released.
module nios2_sysid_checker
    import nios2_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    id_mismatch,
    output logic                    ts_mismatch,
    output logic                    timeout,
    output logic [31:0]             captured_id,
    output logic [31:0]             captured_ts,
    nios2_sysid_checker_if.master   av
);

    sysid_chk_state_t state_r, state_nxt_s;

    logic        busy_r, done_r, pass_r, id_mis_r, ts_mis_r, timeout_r, av_read_r, av_addr_r;
    logic [31:0] cap_id_r, cap_ts_r;
    logic        busy_nxt_s, done_nxt_s, pass_nxt_s, id_mis_nxt_s, ts_mis_nxt_s, timeout_nxt_s;
    logic        av_read_nxt_s, av_addr_nxt_s;
    logic [31:0] cap_id_nxt_s, cap_ts_nxt_s;
    logic        tmo_load_s, tmo_en_s, tmo_expired_s, start_s;

`ifdef SYSID_CHK_AUTOSTART_EN
    logic auto_start_r;

    // One-shot: high throughout reset, so it is still high on the first cycle after release.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_start_r <= 1'b1;
        end else begin
            auto_start_r <= 1'b0;
        end
    end

    assign start_s = start | auto_start_r;
`else
    assign start_s = start;
`endif

    nios2_sysid_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (tmo_load_s),
        .enable  (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // Next-state, capture and flag logic; returned data takes priority over an expiring timer.
    always_comb begin
        state_nxt_s   = state_r;
        pass_nxt_s    = pass_r;
        id_mis_nxt_s  = id_mis_r;
        ts_mis_nxt_s  = ts_mis_r;
        timeout_nxt_s = timeout_r;
        cap_id_nxt_s  = cap_id_r;
        cap_ts_nxt_s  = cap_ts_r;
        tmo_load_s    = 1'b0;
        tmo_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    pass_nxt_s    = 1'b0;
                    id_mis_nxt_s  = 1'b0;
                    ts_mis_nxt_s  = 1'b0;
                    timeout_nxt_s = 1'b0;
                    tmo_load_s    = 1'b1;
                    state_nxt_s   = ST_RD_ID_REQ;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RD_ID_REQ, ST_RD_ID_WAIT: begin
                tmo_en_s = 1'b1;
                // Zero-latency slaves return data in the acceptance cycle itself.
                if (av.av_readdatavalid && ((state_r == ST_RD_ID_WAIT) || !av.av_waitrequest)) begin
                    cap_id_nxt_s = av.av_readdata;
                    id_mis_nxt_s = sysid_word_mismatch(av.av_readdata, EXPECTED_ID);
                    tmo_load_s   = 1'b1;
                    state_nxt_s  = ST_RD_TS_REQ;
                end else if (tmo_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_FINISH;
                end else if ((state_r == ST_RD_ID_REQ) && !av.av_waitrequest) begin
                    state_nxt_s   = ST_RD_ID_WAIT;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            ST_RD_TS_REQ, ST_RD_TS_WAIT: begin
                tmo_en_s = 1'b1;
                if (av.av_readdatavalid && ((state_r == ST_RD_TS_WAIT) || !av.av_waitrequest)) begin
                    cap_ts_nxt_s = av.av_readdata;
                    ts_mis_nxt_s = sysid_word_mismatch(av.av_readdata, EXPECTED_TS);
                    state_nxt_s  = ST_FINISH;
                end else if (tmo_expired_s) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_FINISH;
                end else if ((state_r == ST_RD_TS_REQ) && !av.av_waitrequest) begin
                    state_nxt_s   = ST_RD_TS_WAIT;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_nxt_s == ST_FINISH) begin
            pass_nxt_s = !id_mis_nxt_s && !ts_mis_nxt_s && !timeout_nxt_s;
        end else begin
            pass_nxt_s = pass_nxt_s;
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        busy_nxt_s    = (state_nxt_s inside {ST_RD_ID_REQ, ST_RD_ID_WAIT, ST_RD_TS_REQ, ST_RD_TS_WAIT});
        done_nxt_s    = (state_nxt_s == ST_FINISH);
        av_read_nxt_s = (state_nxt_s == ST_RD_ID_REQ) || (state_nxt_s == ST_RD_TS_REQ);
        if (state_nxt_s == ST_RD_TS_REQ) begin
            av_addr_nxt_s = SYSID_ADDR_TS;
        end else begin
            av_addr_nxt_s = SYSID_ADDR_ID;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            id_mis_r  <= 1'b0;
            ts_mis_r  <= 1'b0;
            timeout_r <= 1'b0;
            cap_id_r  <= 32'd0;
            cap_ts_r  <= 32'd0;
            av_read_r <= 1'b0;
            av_addr_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
            id_mis_r  <= id_mis_nxt_s;
            ts_mis_r  <= ts_mis_nxt_s;
            timeout_r <= timeout_nxt_s;
            cap_id_r  <= cap_id_nxt_s;
            cap_ts_r  <= cap_ts_nxt_s;
            av_read_r <= av_read_nxt_s;
            av_addr_r <= av_addr_nxt_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign id_mismatch   = id_mis_r;
    assign ts_mismatch   = ts_mis_r;
    assign timeout       = timeout_r;
    assign captured_id   = cap_id_r;
    assign captured_ts   = cap_ts_r;
    assign av.av_read    = av_read_r;
    assign av.av_address = av_addr_r;

endmodule

// File: tb/tb_nios2_sysid_checker.sv
// Testbench for nios2_sysid_checker: configurable sysid slave model plus a
// transaction-level reference model of the expected results and latency.
module tb_nios2_sysid_checker;

    localparam int          TMO    = 16;
    localparam logic [31:0] EXP_ID = 32'd1;
    localparam logic [31:0] EXP_TS = 32'd1501838636;
    localparam int          NEVER  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] captured_id, captured_ts;

    nios2_sysid_checker_if av();

    nios2_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_mismatch (id_mismatch),
        .ts_mismatch (ts_mismatch),
        .timeout     (timeout),
        .captured_id (captured_id),
        .captured_ts (captured_ts),
        .av          (av)
    );

    always #5 clock = ~clock;

    // Slave configuration per address: stall cycles, latency (0, 1 or NEVER), data.
    int          cfg_wait [2];
    int          cfg_lat  [2];
    logic [31:0] cfg_data [2];
    int          rd_cycles[2];

    int passed = 0;
    int total  = 0;

    // Model of the captured words, which persist across checks until overwritten.
    logic [31:0] m_cap_id = 32'd0;
    logic [31:0] m_cap_ts = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {28'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout,
                                av.av_read, av.av_address}, 32'd0);
        check({tag, "_cap_id"}, captured_id, 32'd0);
        check({tag, "_cap_ts"}, captured_ts, 32'd0);
    endtask

    // Slave model, updated on the falling edge so the DUT sees stable inputs.
    initial begin
        int          wait_left;
        bit          req_active;
        bit          pend;
        logic [31:0] pend_data;
        int          a;
        wait_left = 0; req_active = 1'b0; pend = 1'b0; pend_data = 32'd0;
        av.av_waitrequest   = 1'b0;
        av.av_readdata      = 32'd0;
        av.av_readdatavalid = 1'b0;
        forever begin
            @(negedge clock);
            av.av_readdatavalid = 1'b0;
            av.av_waitrequest   = 1'b0;
            if (reset) begin
                req_active = 1'b0;
                pend       = 1'b0;
            end else begin
                if (pend) begin
                    av.av_readdatavalid = 1'b1;
                    av.av_readdata      = pend_data;
                    pend                = 1'b0;
                end
                if (av.av_read === 1'b1) begin
                    a = (av.av_address === 1'b1) ? 1 : 0;
                    rd_cycles[a]++;
                    if (!req_active) begin
                        req_active = 1'b1;
                        wait_left  = cfg_wait[a];
                    end
                    if (wait_left > 0) begin
                        av.av_waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        req_active = 1'b0;
                        if (cfg_lat[a] == 0) begin
                            av.av_readdatavalid = 1'b1;
                            av.av_readdata      = cfg_data[a];
                        end else if (cfg_lat[a] == 1) begin
                            pend      = 1'b1;
                            pend_data = cfg_data[a];
                        end
                    end
                end else begin
                    req_active = 1'b0;
                end
            end
        end
    end

    // Run one check from IDLE and compare every result against the reference model.
    task automatic do_check(input string tag,
                            input int wid, input int lid, input logic [31:0] did,
                            input int wts, input int lts, input logic [31:0] dts,
                            input bit poke_finish);
        int cyc, n;
        bit e_tmo, e_idm, e_tsm;
        cfg_wait[0] = wid; cfg_lat[0] = lid; cfg_data[0] = did;
        cfg_wait[1] = wts; cfg_lat[1] = lts; cfg_data[1] = dts;
        rd_cycles[0] = 0; rd_cycles[1] = 0;
        e_tmo = 1'b0; e_idm = 1'b0; e_tsm = 1'b0;
        if (lid == NEVER) begin
            e_tmo = 1'b1;
            cyc   = TMO;
        end else begin
            cyc      = wid + 1 + lid;
            m_cap_id = did;
            e_idm    = (did != EXP_ID);
            if (lts == NEVER) begin
                e_tmo = 1'b1;
                cyc   = cyc + TMO;
            end else begin
                cyc      = cyc + wts + 1 + lts;
                m_cap_ts = dts;
                e_tsm    = (dts != EXP_TS);
            end
        end
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, n, cyc);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, {27'd0, busy, pass, id_mismatch, ts_mismatch, timeout},
              {27'd0, 1'b0, !e_tmo && !e_idm && !e_tsm, e_idm, e_tsm, e_tmo});
        check({tag, "_cap_id"}, captured_id, m_cap_id);
        check({tag, "_cap_ts"}, captured_ts, m_cap_ts);
        check({tag, "_av_read"}, {31'd0, av.av_read}, 32'd0);
        if (poke_finish) begin
            start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        check({tag, "_after"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        cfg_wait[0] = 0; cfg_lat[0] = 1; cfg_data[0] = EXP_ID;
        cfg_wait[1] = 0; cfg_lat[1] = 1; cfg_data[1] = EXP_TS;
        rd_cycles[0] = 0; rd_cycles[1] = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
`ifdef SYSID_CHK_AUTOSTART_EN
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("auto_done", {31'd0, done}, 32'd1);
        check("auto_pass", {31'd0, pass}, 32'd1);
        check("auto_cap_ts", captured_ts, EXP_TS);
`else
        repeat (5) @(negedge clock);
        check("no_autorun", {30'd0, busy, av.av_read}, 32'd0);

        do_check("t1_basic", 0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0);
        do_check("t2_bad_id", 0, 1, 32'd2, 0, 1, EXP_TS, 1'b1);
        do_check("t3_ts_stall", 0, 1, EXP_ID, 5, 1, EXP_TS, 1'b0);
        check("t3_ts_req_cycles", rd_cycles[1], 32'd6);
        do_check("t4_timeout", 0, NEVER, EXP_ID, 0, 1, EXP_TS, 1'b0);
        do_check("zero_latency", 0, 0, EXP_ID, 0, 0, EXP_TS, 1'b0);
        do_check("bad_ts", 2, 0, EXP_ID, 1, 1, 32'h1234_5678, 1'b0);
        do_check("ts_timeout", 1, 1, EXP_ID, 0, NEVER, EXP_TS, 1'b0);

        // Start re-pulsed while busy, then reset during the timestamp wait.
        cfg_wait[0] = 0; cfg_lat[0] = 1;     cfg_data[0] = EXP_ID;
        cfg_wait[1] = 0; cfg_lat[1] = NEVER; cfg_data[1] = EXP_TS;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t5_ts_req", {30'd0, av.av_read, av.av_address}, 32'd3);
        @(negedge clock);
        check("t5_ts_wait", {30'd0, busy, av.av_read}, 32'd2);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        m_cap_id = 32'd0;
        m_cap_ts = 32'd0;
        check_all_zero("t5_reset");
        reset = 1'b0;
        @(negedge clock);
        do_check("t5_fresh", 0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0);

        for (int i = 0; i < 12; i++) begin
            int          wi, li, wt, lt;
            logic [31:0] di, dt;
            wi = $urandom_range(0, 3);
            wt = $urandom_range(0, 3);
            li = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 1);
            lt = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 1);
            di = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            dt = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            do_check($sformatf("rand%0d", i), wi, li, di, wt, lt, dt, 1'(i % 2));
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
